// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//    Bundles every handshake and bus signal of the IF/MEM-to-memory arbiter.
//    Clock and reset are not included; they stay scalar module ports.
//
// Signal summary:
//    IF requester : in_if_req, in_if_addr            -> arbiter
//                   out_if_valid, out_if_data,
//                   out_if_stall                     <- arbiter
//    MEM requester: in_mem_req, in_mem_write,
//                   in_mem_addr, in_mem_wdata        -> arbiter
//                   out_mem_valid, out_mem_rdata,
//                   out_mem_stall                    <- arbiter
//    Memory       : out_mm_req, out_mm_write,
//                   out_mm_addr, out_mm_wdata        <- arbiter
//                   in_mm_resp_valid, in_mm_resp_data -> arbiter
//
// Modports:
//    slave  - the arbiter's view (consumes in_*, drives out_*).
//    master - the environment's view (pipeline stages and memory model).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic                  in_if_req;
   logic [ADDR_WIDTH-1:0] in_if_addr;
   logic                  out_if_valid;
   logic [DATA_WIDTH-1:0] out_if_data;
   logic                  out_if_stall;

   logic                  in_mem_req;
   logic                  in_mem_write;
   logic [ADDR_WIDTH-1:0] in_mem_addr;
   logic [DATA_WIDTH-1:0] in_mem_wdata;
   logic                  out_mem_valid;
   logic [DATA_WIDTH-1:0] out_mem_rdata;
   logic                  out_mem_stall;

   logic                  out_mm_req;
   logic                  out_mm_write;
   logic [ADDR_WIDTH-1:0] out_mm_addr;
   logic [DATA_WIDTH-1:0] out_mm_wdata;
   logic                  in_mm_resp_valid;
   logic [DATA_WIDTH-1:0] in_mm_resp_data;

   modport slave (
      input  in_if_req, in_if_addr,
      output out_if_valid, out_if_data, out_if_stall,
      input  in_mem_req, in_mem_write, in_mem_addr, in_mem_wdata,
      output out_mem_valid, out_mem_rdata, out_mem_stall,
      output out_mm_req, out_mm_write, out_mm_addr, out_mm_wdata,
      input  in_mm_resp_valid, in_mm_resp_data
   );

   modport master (
      output in_if_req, in_if_addr,
      input  out_if_valid, out_if_data, out_if_stall,
      output in_mem_req, in_mem_write, in_mem_addr, in_mem_wdata,
      input  out_mem_valid, out_mem_rdata, out_mem_stall,
      input  out_mm_req, out_mm_write, out_mm_addr, out_mm_wdata,
      output in_mm_resp_valid, in_mm_resp_data
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares one single-ported, variable-latency unified memory between the IF
//    stage (read-only fetch) and the MEM stage (load/store). At most one
//    transaction is outstanding. The winner's request goes to memory as a
//    one-cycle pulse and the response comes back as a one-cycle valid pulse to
//    that requester. MEM normally has priority over IF because it carries the
//    older instruction.
//
// Ports:
//    clk    - rising-edge clock
//    reset  - synchronous, active-high reset
//    bus    - mem_port_arbiter_if.slave: IF and MEM requester handshakes,
//             stall outputs, and the memory request/response port
//
// Timing:
//    req sampled in cycle 0 -> out_mm_req in cycle 1 -> response no earlier
//    than cycle 2 -> out_x_valid the cycle after the response.
//
// Build option:
//    MEM_ARB_FAIRNESS_EN - when defined, a counter of MEM grants made while
//    IF is waiting forces an IF grant once it reaches FAIR_LIMIT. When not
//    defined, MEM priority is strict and IF can starve.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FAIR_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_IF  = 2'd1,
      WAIT_MEM = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Arbitration and completion strobes
   logic if_eligible;
   logic mem_eligible;
   logic force_if;
   logic resp_take;
   logic grant_if;
   logic grant_mem;
   logic done_if;
   logic done_mem;

   // Registered output copies
   logic                  mm_req;
   logic                  mm_write;
   logic [ADDR_WIDTH-1:0] mm_addr;
   logic [DATA_WIDTH-1:0] mm_wdata;
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_data;
   logic                  mem_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // A zero limit would make the fairness counter meaningless
   if (FAIR_LIMIT < 1) begin : g_bad_fair_limit
      $error("mem_port_arbiter: FAIR_LIMIT must be at least 1");
   end

   // A requester whose valid pulse is out this cycle was just served; its
   // req may still be high, so it must not win again.
   assign if_eligible  = bus.in_if_req  & ~if_valid;
   assign mem_eligible = bus.in_mem_req & ~mem_valid;

   // A response in the same cycle as the request pulse is too early to be
   // genuine and is dropped. Only registered state is involved, so there is
   // no combinational path from in_mm_* to out_mm_*.
   assign resp_take = bus.in_mm_resp_valid & ~mm_req;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int CNT_WIDTH = $clog2(FAIR_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] FAIR_LIMIT_C = CNT_WIDTH'(FAIR_LIMIT);

   logic [CNT_WIDTH-1:0] fair_cnt;

   // Fairness counter: counts MEM grants that overtook a waiting IF request
   always_ff @(posedge clk) begin
      if (reset) begin
         fair_cnt <= {CNT_WIDTH{1'b0}};
      end else if (grant_if) begin
         fair_cnt <= {CNT_WIDTH{1'b0}};
      end else if (grant_mem && bus.in_if_req && (fair_cnt != FAIR_LIMIT_C)) begin
         fair_cnt <= fair_cnt + CNT_WIDTH'(1);
      end
   end

   assign force_if = (fair_cnt == FAIR_LIMIT_C);
`else
   assign force_if = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_mem) begin
               state_next = WAIT_MEM;
            end else if (grant_if) begin
               state_next = WAIT_IF;
            end else begin
               state_next = IDLE;
            end
         end
         WAIT_IF: begin
            if (resp_take) begin
               state_next = IDLE;
            end else begin
               state_next = WAIT_IF;
            end
         end
         WAIT_MEM: begin
            if (resp_take) begin
               state_next = IDLE;
            end else begin
               state_next = WAIT_MEM;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM output logic: grant and completion strobes feeding the output registers
   always_comb begin
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      done_if   = 1'b0;
      done_mem  = 1'b0;
      case (state)
         IDLE: begin
            // MEM wins unless the fairness limit hands this round to IF
            if (mem_eligible && !(if_eligible && force_if)) begin
               grant_mem = 1'b1;
            end else if (if_eligible) begin
               grant_if = 1'b1;
            end else begin
               grant_mem = 1'b0;
               grant_if  = 1'b0;
            end
         end
         WAIT_IF: begin
            if (resp_take) begin
               done_if = 1'b1;
            end else begin
               done_if = 1'b0;
            end
         end
         WAIT_MEM: begin
            if (resp_take) begin
               done_mem = 1'b1;
            end else begin
               done_mem = 1'b0;
            end
         end
         default: begin
            grant_if  = 1'b0;
            grant_mem = 1'b0;
            done_if   = 1'b0;
            done_mem  = 1'b0;
         end
      endcase
   end

   // Memory request registers: pulse for one cycle, address/data hold until next grant
   always_ff @(posedge clk) begin
      if (reset) begin
         mm_req   <= 1'b0;
         mm_write <= 1'b0;
         mm_addr  <= {ADDR_WIDTH{1'b0}};
         mm_wdata <= {DATA_WIDTH{1'b0}};
      end else begin
         mm_req <= grant_if | grant_mem;
         if (grant_mem) begin
            mm_write <= bus.in_mem_write;
            mm_addr  <= bus.in_mem_addr;
            mm_wdata <= bus.in_mem_wdata;
         end else if (grant_if) begin
            mm_write <= 1'b0;
            mm_addr  <= bus.in_if_addr;
            mm_wdata <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Response registers: one-cycle valid, data holds until the next valid
   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid  <= 1'b0;
         if_data   <= {DATA_WIDTH{1'b0}};
         mem_valid <= 1'b0;
         mem_rdata <= {DATA_WIDTH{1'b0}};
      end else begin
         if_valid  <= done_if;
         mem_valid <= done_mem;
         if (done_if) begin
            if_data <= bus.in_mm_resp_data;
         end
         // mm_write still describes the outstanding MEM transaction here;
         // stores report zero read data.
         if (done_mem) begin
            mem_rdata <= mm_write ? {DATA_WIDTH{1'b0}} : bus.in_mm_resp_data;
         end
      end
   end

   assign bus.out_mm_req    = mm_req;
   assign bus.out_mm_write  = mm_write;
   assign bus.out_mm_addr   = mm_addr;
   assign bus.out_mm_wdata  = mm_wdata;
   assign bus.out_if_valid  = if_valid;
   assign bus.out_if_data   = if_data;
   assign bus.out_mem_valid = mem_valid;
   assign bus.out_mem_rdata = mem_rdata;

   // Stalls follow req and valid directly so hazard logic sees them in the same cycle
   assign bus.out_if_stall  = bus.in_if_req  & ~if_valid;
   assign bus.out_mem_stall = bus.in_mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled on the falling edge. Expected
// values are hand-computed from the cycle-level timing of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic reset;

   int err_count;
   int chk_count;
   int mm_req_pulses;
   int pulses_snap;
   int if_grants;
   logic exp_if;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .FAIR_LIMIT(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count memory request pulses as seen in the middle of each cycle
   always @(negedge clk) begin
      if (bus.out_mm_req === 1'b1) begin
         mm_req_pulses <= mm_req_pulses + 1;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      chk_count = chk_count + 1;
      if (actual !== expected) begin
         err_count = err_count + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge (drive point)
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Advance to the falling edge of the current cycle (sample point)
   task automatic mid();
      @(negedge clk);
   endtask

   // Safety net against a hung simulation
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      err_count     = 0;
      chk_count     = 0;
      mm_req_pulses = 0;
      if_grants     = 0;
      reset                = 1'b1;
      bus.in_if_req        = 1'b0;
      bus.in_if_addr       = 32'h0;
      bus.in_mem_req       = 1'b0;
      bus.in_mem_write     = 1'b0;
      bus.in_mem_addr      = 32'h0;
      bus.in_mem_wdata     = 32'h0;
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;

      // ---------------- reset state ----------------
      repeat (2) cyc();
      mid();
      check_value("rst_mm_req",    32'(bus.out_mm_req),    32'h0);
      check_value("rst_mm_addr",   bus.out_mm_addr,        32'h0);
      check_value("rst_if_valid",  32'(bus.out_if_valid),  32'h0);
      check_value("rst_mem_valid", 32'(bus.out_mem_valid), 32'h0);
      check_value("rst_if_data",   bus.out_if_data,        32'h0);
      check_value("rst_mem_rdata", bus.out_mem_rdata,      32'h0);

      // ---------------- T1: single IF read ----------------
      cyc();
      reset = 1'b0;
      bus.in_if_req  = 1'b1;
      bus.in_if_addr = 32'h0000_0100;
      mid();
      check_value("t1_stall_c0",  32'(bus.out_if_stall), 32'h1);
      check_value("t1_mmreq_c0",  32'(bus.out_mm_req),   32'h0);
      cyc(); mid();
      check_value("t1_mmreq_c1",  32'(bus.out_mm_req),   32'h1);
      check_value("t1_mmaddr_c1", bus.out_mm_addr,       32'h0000_0100);
      check_value("t1_mmwr_c1",   32'(bus.out_mm_write), 32'h0);
      check_value("t1_stall_c1",  32'(bus.out_if_stall), 32'h1);
      cyc(); mid();
      check_value("t1_mmreq_c2",  32'(bus.out_mm_req),   32'h0);
      check_value("t1_stall_c2",  32'(bus.out_if_stall), 32'h1);
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h00A0_0093;
      mid();
      check_value("t1_valid_c3",  32'(bus.out_if_valid), 32'h0);
      check_value("t1_stall_c3",  32'(bus.out_if_stall), 32'h1);
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t1_valid_c4",  32'(bus.out_if_valid), 32'h1);
      check_value("t1_data_c4",   bus.out_if_data,       32'h00A0_0093);
      check_value("t1_stall_c4",  32'(bus.out_if_stall), 32'h0);
      cyc();
      bus.in_if_req = 1'b0;
      mid();
      check_value("t1_valid_c5",  32'(bus.out_if_valid), 32'h0);
      check_value("t1_hold_c5",   bus.out_if_data,       32'h00A0_0093);
      check_value("t1_mmreq_c5",  32'(bus.out_mm_req),   32'h0);

      // ---------------- T2: simultaneous IF read and MEM store ----------------
      cyc();
      bus.in_if_req    = 1'b1;
      bus.in_if_addr   = 32'h0000_0200;
      bus.in_mem_req   = 1'b1;
      bus.in_mem_write = 1'b1;
      bus.in_mem_addr  = 32'h0000_0400;
      bus.in_mem_wdata = 32'hDEAD_BEEF;
      mid();
      check_value("t2_ifstall_c0",  32'(bus.out_if_stall),  32'h1);
      check_value("t2_memstall_c0", 32'(bus.out_mem_stall), 32'h1);
      cyc(); mid();
      check_value("t2_mmreq_c1",   32'(bus.out_mm_req),   32'h1);
      check_value("t2_mmwr_c1",    32'(bus.out_mm_write), 32'h1);
      check_value("t2_mmaddr_c1",  bus.out_mm_addr,       32'h0000_0400);
      check_value("t2_mmwdata_c1", bus.out_mm_wdata,      32'hDEAD_BEEF);
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h5555_5555;
      mid();
      check_value("t2_memvalid_c2", 32'(bus.out_mem_valid), 32'h0);
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t2_memvalid_c3", 32'(bus.out_mem_valid), 32'h1);
      check_value("t2_memrdata_c3", bus.out_mem_rdata,      32'h0);
      check_value("t2_ifvalid_c3",  32'(bus.out_if_valid),  32'h0);
      check_value("t2_mmreq_c3",    32'(bus.out_mm_req),    32'h0);
      cyc();
      bus.in_mem_req = 1'b0;
      mid();
      check_value("t2_mmreq_c4",    32'(bus.out_mm_req),    32'h1);
      check_value("t2_mmaddr_c4",   bus.out_mm_addr,        32'h0000_0200);
      check_value("t2_mmwr_c4",     32'(bus.out_mm_write),  32'h0);
      check_value("t2_memvalid_c4", 32'(bus.out_mem_valid), 32'h0);
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h1122_3344;
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t2_ifvalid_c6", 32'(bus.out_if_valid), 32'h1);
      check_value("t2_ifdata_c6",  bus.out_if_data,       32'h1122_3344);
      cyc();
      bus.in_if_req = 1'b0;
      mid();
      check_value("t2_mmreq_c7",   32'(bus.out_mm_req),   32'h0);

      // ---------------- T3: MEM load, early response ignored, req held through valid ----------------
      cyc();
      pulses_snap      = mm_req_pulses;
      bus.in_mem_req   = 1'b1;
      bus.in_mem_write = 1'b0;
      bus.in_mem_addr  = 32'h0000_0404;
      bus.in_mem_wdata = 32'h0;
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'hBAD0_BAD0;
      mid();
      check_value("t3_mmreq_c1",  32'(bus.out_mm_req), 32'h1);
      check_value("t3_mmaddr_c1", bus.out_mm_addr,     32'h0000_0404);
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t3_memvalid_c2", 32'(bus.out_mem_valid), 32'h0);
      check_value("t3_memstall_c2", 32'(bus.out_mem_stall), 32'h1);
      cyc(); mid();
      check_value("t3_memvalid_c3", 32'(bus.out_mem_valid), 32'h0);
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'hCAFE_F00D;
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t3_memvalid_c5", 32'(bus.out_mem_valid), 32'h1);
      check_value("t3_memrdata_c5", bus.out_mem_rdata,      32'hCAFE_F00D);
      check_value("t3_memstall_c5", 32'(bus.out_mem_stall), 32'h0);
      cyc();
      bus.in_mem_req = 1'b0;
      mid();
      check_value("t3_memvalid_c6", 32'(bus.out_mem_valid), 32'h0);
      check_value("t3_mmreq_c6",    32'(bus.out_mm_req),    32'h0);
      cyc(); mid();
      check_value("t3_mmreq_c7",    32'(bus.out_mm_req),    32'h0);
      check_value("t3_pulses",      32'(mm_req_pulses - pulses_snap), 32'h1);

      // ---------------- T6: response while IDLE is ignored ----------------
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h0000_1234;
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t6_ifvalid",  32'(bus.out_if_valid),  32'h0);
      check_value("t6_memvalid", 32'(bus.out_mem_valid), 32'h0);
      check_value("t6_mmreq",    32'(bus.out_mm_req),    32'h0);
      check_value("t6_ifdata",   bus.out_if_data,        32'h1122_3344);
      check_value("t6_memrdata", bus.out_mem_rdata,      32'hCAFE_F00D);
      cyc();
      bus.in_if_req  = 1'b1;
      bus.in_if_addr = 32'h0000_0300;
      cyc(); mid();
      check_value("t6_idle_mmreq",  32'(bus.out_mm_req), 32'h1);
      check_value("t6_idle_mmaddr", bus.out_mm_addr,     32'h0000_0300);
      cyc();
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h0000_0013;
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t6_ifdata_after", bus.out_if_data, 32'h0000_0013);
      cyc();
      bus.in_if_req = 1'b0;

      // ---------------- T4: reset while waiting on a MEM load ----------------
      cyc();
      bus.in_mem_req   = 1'b1;
      bus.in_mem_write = 1'b0;
      bus.in_mem_addr  = 32'h0000_0500;
      cyc(); mid();
      check_value("t4_mmreq_c1", 32'(bus.out_mm_req), 32'h1);
      cyc();
      reset          = 1'b1;
      bus.in_mem_req = 1'b0;
      cyc();
      reset                = 1'b0;
      pulses_snap          = mm_req_pulses;
      bus.in_mm_resp_valid = 1'b1;
      bus.in_mm_resp_data  = 32'h0000_0077;
      mid();
      check_value("t4_mmreq_r",    32'(bus.out_mm_req),    32'h0);
      check_value("t4_mmaddr_r",   bus.out_mm_addr,        32'h0);
      check_value("t4_memvalid_r", 32'(bus.out_mem_valid), 32'h0);
      check_value("t4_ifdata_r",   bus.out_if_data,        32'h0);
      check_value("t4_memrdata_r", bus.out_mem_rdata,      32'h0);
      cyc();
      bus.in_mm_resp_valid = 1'b0;
      bus.in_mm_resp_data  = 32'h0;
      mid();
      check_value("t4_memvalid_late", 32'(bus.out_mem_valid), 32'h0);
      check_value("t4_memrdata_late", bus.out_mem_rdata,      32'h0);
      cyc(); mid();
      check_value("t4_mmreq_late", 32'(bus.out_mm_req), 32'h0);
      check_value("t4_pulses",     32'(mm_req_pulses - pulses_snap), 32'h0);

      // ---------------- T5: MEM pressure with IF waiting ----------------
      for (int k = 0; k < 20; k++) begin
         cyc();
         bus.in_if_req    = 1'b1;
         bus.in_if_addr   = 32'h0000_0600;
         bus.in_mem_req   = 1'b1;
         bus.in_mem_write = 1'b0;
         bus.in_mem_addr  = 32'h0000_0700;
`ifdef MEM_ARB_FAIRNESS_EN
         exp_if = ((k % 5) == 4);
`else
         exp_if = 1'b0;
`endif
         cyc(); mid();
         check_value("t5_grant_addr", bus.out_mm_addr, exp_if ? 32'h0000_0600 : 32'h0000_0700);
         if (bus.out_mm_addr == 32'h0000_0600) begin
            if_grants = if_grants + 1;
         end
         cyc();
         bus.in_mm_resp_valid = 1'b1;
         bus.in_mm_resp_data  = 32'(k);
         cyc();
         bus.in_mm_resp_valid = 1'b0;
         bus.in_mm_resp_data  = 32'h0;
         bus.in_if_req        = 1'b0;
         bus.in_mem_req       = 1'b0;
         mid();
         check_value("t5_winner_valid",
                     32'(exp_if ? bus.out_if_valid : bus.out_mem_valid), 32'h1);
         cyc();
      end
`ifdef MEM_ARB_FAIRNESS_EN
      check_value("t5_if_grants", 32'(if_grants), 32'd4);
`else
      check_value("t5_if_grants", 32'(if_grants), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", err_count, chk_count);
      $finish;
   end

endmodule
